// File: rtl/memory_port_arbiter_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the
// instruction/data memory port arbiter.
package memory_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_ACK,
        LOAD_ACK,
        RMW_WRITE,
        STORE_ACK,
        ERROR
    } MemArbState_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } Grant_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return funct3 > SW;
        end
        return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

    // Only meaningful for legal funct3; loads and stores share the size encoding.
    function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            LH, LHU: return offset[0];
            LW:      return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_lane_formatter.sv
// Combinational lane logic: load byte/halfword extraction with extension, and
// store merge of byte/halfword data into an existing memory word.
module memory_lane_formatter
    import memory_port_arbiter_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = word[{byte_offset, 3'b000} +: 8];
    assign sel_half = byte_offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (funct3)
            LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
            LH:      load_data = {{16{sel_half[15]}}, sel_half};
            LBU:     load_data = {24'd0, sel_byte};
            LHU:     load_data = {16'd0, sel_half};
            default: load_data = word;
        endcase
    end

    // Each byte lane takes store data when the access covers it, else keeps the old byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] lane_src;

        assign lane_hit = (funct3 == SB) ? (byte_offset == LANE) :
                          (funct3 == SH) ? (byte_offset[1] == LANE[1]) : 1'b1;
        assign lane_src = (funct3 == SB) ? store_data[7:0] :
                          (funct3 == SH) ? store_data[8*(gi%2) +: 8] : store_data[8*gi +: 8];
        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : word[8*gi +: 8];
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and load/store access to a single-ported synchronous memory,
// sequencing read-modify-write for sub-word stores and latching sticky errors.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic                  fetchReady,
    output logic [31:0]           fetchData,
    input  logic                  dataRequest,
    input  logic                  dataWrite,
    input  logic [2:0]            dataFunct3,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [31:0]           dataWriteData,
    output logic                  dataReady,
    output logic [31:0]           dataReadData,
    output logic [ADDR_WIDTH-3:0] memAddress,
    output logic                  memWriteEnable,
    output logic [31:0]           memWriteData,
    input  logic [31:0]           memReadData,
    output logic                  unalignedAccess,
    output logic                  badFunct3
);

    MemArbState_t          state_reg, state_next;
    Grant_t                last_grant_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  unaligned_reg;
    logic                  bad_funct3_reg;

    logic                  grant_valid;
    logic                  grant_data;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  grant_unaligned;
    logic                  grant_bad_funct3;
    logic [31:0]           load_data;
    logic [31:0]           merged_word;

    // Grants are suppressed while reset is high so every output sits at its reset value.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = 1'b0;
        if (state_reg == IDLE && !reset) begin
            grant_valid = fetchRequest | dataRequest;
            grant_data  = (fetchRequest && dataRequest) ? (last_grant_reg == GRANT_FETCH)
                                                        : dataRequest;
        end
        grant_addr       = grant_data ? dataAddress : fetchAddress;
        grant_bad_funct3 = grant_valid && grant_data && funct3_illegal(dataWrite, dataFunct3);
        grant_unaligned  = grant_valid && !grant_bad_funct3 &&
                           (grant_data ? access_misaligned(dataFunct3, grant_addr[1:0])
                                       : (grant_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_next     = state_reg;
        memWriteEnable = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_bad_funct3 || grant_unaligned) begin
                        state_next = ERROR;
                    end else if (!grant_data) begin
                        state_next = FETCH_ACK;
                    end else if (!dataWrite) begin
                        state_next = LOAD_ACK;
                    end else if (dataFunct3 == SW) begin
                        state_next     = STORE_ACK;
                        memWriteEnable = 1'b1;
                    end else begin
                        state_next = RMW_WRITE;
                    end
                end
            end
            RMW_WRITE: begin
                memWriteEnable = 1'b1;
                state_next     = STORE_ACK;
            end
            FETCH_ACK, LOAD_ACK, STORE_ACK: state_next = IDLE;
            default:                        state_next = state_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_FETCH;
            addr_reg       <= '0;
            unaligned_reg  <= 1'b0;
            bad_funct3_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_valid) begin
                last_grant_reg <= grant_data ? GRANT_DATA : GRANT_FETCH;
                addr_reg       <= grant_addr;
            end
            if (grant_unaligned) unaligned_reg <= 1'b1;
            if (grant_bad_funct3) bad_funct3_reg <= 1'b1;
        end
    end

    // Lane formatting uses the latched address; the requester holds funct3 and store data.
    memory_lane_formatter u_formatter (
        .word        (memReadData),
        .store_data  (dataWriteData),
        .byte_offset (addr_reg[1:0]),
        .funct3      (dataFunct3),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign memAddress      = grant_valid ? grant_addr[ADDR_WIDTH-1:2] : addr_reg[ADDR_WIDTH-1:2];
    assign memWriteData    = merged_word;
    assign fetchReady      = (state_reg == FETCH_ACK);
    assign fetchData       = memReadData;
    assign dataReady       = (state_reg == LOAD_ACK) || (state_reg == STORE_ACK);
    assign dataReadData    = load_data;
    assign unalignedAccess = unaligned_reg;
    assign badFunct3       = bad_funct3_reg;

endmodule
